int_controller: RTL and testbench
=================================

Name: int_controller

Overview:
- Interrupt controller between cpu_top's peripheral sources (timer_int, debounced button_in bits) and the pipelined core's exception logic.
- Latches rising edges into a pending register, applies a software mask and global enable, and picks the highest-priority source.
- Raises one request to the pipeline, then holds in-service state until the core executes eret.
- Memory-mapped registers are accessed through the MEM-stage I/O decode.

Parameters:
N_SRC, 8, number of interrupt sources (1..16); bit 0 = timer_int, bits 5:1 = button_out[4:0]
ID_W, 4, width of the source-id field; must satisfy 2^ID_W >= N_SRC
MASK_RST, 0, reset value of MASK[N_SRC-1:0]; 0 = all sources masked

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
src_in  in  N_SRC  raw level interrupt sources; a rising edge requests service
reg_we  in  1  MMIO write strobe, one cycle
reg_addr  in  2  word select: 0 = MASK (RW), 1 = PENDING (R, write-1-to-clear), 2 = CTRL (bit0 GIE, RW), 3 = STATUS (R)
reg_wdata  in  32  MMIO write data
reg_rdata  out  32  MMIO read data, combinational from reg_addr; unused bits read 0
int_req  out  1  registered interrupt request to the pipeline
int_id  out  ID_W  registered id of the requested or in-service source
int_ack  in  1  one-cycle pulse when the pipeline redirects the PC to the handler
eret  in  1  one-cycle pulse when the handler returns

Behaviour:
- Reset: state = IDLE; int_req = 0; int_id = 0; PENDING = 0; MASK = MASK_RST; GIE = 0; edge history = 0; reg_rdata follows reg_addr with reset register contents.
- Edge detect: pending[i] is set at the edge where src_in[i] = 1 and prev[i] = 0. prev updates every cycle.
- Eligible = PENDING & MASK, qualified by GIE. Priority: the lowest index wins.
- IDLE:
  - If eligible != 0, go to REQ; int_id <= winner; int_req <= 1.
  - Latency without sync: src_in rises in cycle t, pending is set at t+1, int_req is high at t+2.
- REQ: int_id is frozen.
  - If int_ack = 1: clear pending[int_id]; go to SERVICE; int_req <= 0.
  - Otherwise, if pending[int_id] = 0 (cleared by W1C), MASK[int_id] = 0, or GIE = 0: go to IDLE; int_req <= 0. Re-arbitration happens from IDLE on a later cycle.
- SERVICE: int_req = 0; int_id holds the in-service id. No new request while in SERVICE (no nesting). eret = 1 -> IDLE.
- int_ack outside REQ and eret outside SERVICE are ignored.
- Simultaneous events:
  - A new edge and a W1C clear of the same bit in one cycle: the set wins.
  - A new edge on the acked source in the ack cycle: the pending bit stays 1.
  - int_ack and an invalidating register write in the same cycle: the ack wins.
- STATUS read: bits[1:0] = state (IDLE = 0, REQ = 1, SERVICE = 2); bits[8+ID_W-1:8] = int_id.
- MMIO writes take effect at the next edge. A write to STATUS has no effect.
- Reset asserted mid-operation: all state clears immediately. A source held high through reset deassertion does not fire until it falls and rises again.

Optional Feature:
- Macro: INT_SYNC_EN.
- Defined: each src_in bit passes through a two-flop synchronizer (reset 0) before edge detection. Source-to-int_req latency becomes 4 cycles.
- Undefined: src_in feeds edge detection directly, with 2-cycle latency. Sources must then be synchronous to clk.

Decomposition:
- Package int_ctrl_pkg holds:
  - state encodings IDLE / REQ / SERVICE;
  - register word offsets MASK / PENDING / CTRL / STATUS;
  - STATUS field positions.
- One natural sub-module, int_prio_enc: a combinational lowest-index-wins priority encoder producing a valid flag and the id.

Test Plan:
- MASK = 0xFF, GIE = 1, src_in[3] rises in cycle t -> int_req = 1 at t+2 with int_id = 3; int_ack -> PENDING bit 3 = 0, STATUS state = 2.
- src_in[5] and src_in[1] rise in the same cycle -> int_id = 1. After ack and eret -> a second request with int_id = 5.
- MASK = 0x00, src_in[2] rises -> PENDING = 0x04, int_req stays 0. Write MASK = 0x04 -> int_req = 1 two cycles after the write.
- In REQ for id 4, write PENDING = 0x10 (W1C) with no ack -> int_req = 0 the next cycle, state = IDLE.
- In SERVICE, src_in[0] rises -> no int_req until eret. After eret -> int_req with int_id = 0.
- Assert rst while in REQ -> int_req, int_id, PENDING, MASK and GIE return to reset values asynchronously. With INT_SYNC_EN defined, the first-case latency is 4 cycles.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared encodings for the interrupt controller: FSM states, MMIO word
// offsets and STATUS field positions.
package int_ctrl_pkg;

  // Controller state, also reported in STATUS[1:0]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // MMIO word offsets
  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // STATUS field positions
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_ID_LSB    = 8;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
module int_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the lowest set index is the last one assigned
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: rising-edge pending latch, software mask, global
// enable, lowest-index priority, one request per interrupt, then in-service
// until eret. Optional build macro INT_SYNC_EN adds a two-flop synchronizer
// on every source ahead of edge detection.
//
// Handshake: int_req is held high while in REQ; the pipeline answers with a
// single-cycle int_ack pulse, after which the controller stays in SERVICE
// (int_req low) until a single-cycle eret pulse. int_ack outside REQ and
// eret outside SERVICE are ignored.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int          N_SRC    = 8,
  parameter int          ID_W     = 4,
  parameter int unsigned MASK_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             eret
);

  state_t           state;
  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nx;
  logic [N_SRC-1:0] mask;
  logic             gie;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_onehot;
  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata[31:N_SRC];

`ifdef INT_SYNC_EN
  // Edges blocked until the synchronizer and history have both filled
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  // Two-flop synchronizer per source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  // Edges blocked for the first cycle so a level held through reset is not an edge
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign src_s = src_in;
`endif

  assign armed     = (arm_cnt == ARM_CYC);
  assign edges     = src_s & ~prev & {N_SRC{armed}};
  assign eligible  = pending & mask & {N_SRC{gie}};
  assign id_onehot = N_SRC'(1) << int_id;

  int_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .id    (win_id)
  );

  // Pending update: W1C and ack clears, new edges take precedence over both
  always_comb begin
    clr = '0;
    if (reg_we && reg_addr == ADDR_PENDING) clr = reg_wdata[N_SRC-1:0];
    if (state == ST_REQ && int_ack) clr = clr | id_onehot;
    pending_nx = (pending & ~clr) | edges;
  end

  // Register file, edge history and post-reset arming counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
      mask    <= N_SRC'(MASK_RST);
      gie     <= 1'b0;
      arm_cnt <= '0;
    end else begin
      prev    <= src_s;
      pending <= pending_nx;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      if (reg_we && reg_addr == ADDR_MASK) mask <= reg_wdata[N_SRC-1:0];
      if (reg_we && reg_addr == ADDR_CTRL) gie <= reg_wdata[0];
    end
  end

  // Request / service FSM with registered int_req and int_id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            int_id  <= win_id;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state   <= ST_SERVICE;
            int_req <= 1'b0;
          end else if (!(|(pending & id_onehot)) || !(|(mask & id_onehot)) || !gie) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          int_req <= 1'b0;
          if (eret) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

  // MMIO read mux, unused bits read as zero
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_MASK:    reg_rdata[N_SRC-1:0] = mask;
      ADDR_PENDING: reg_rdata[N_SRC-1:0] = pending;
      ADDR_CTRL:    reg_rdata[0] = gie;
      default: begin
        reg_rdata[STATUS_STATE_LSB +: 2] = state;
        reg_rdata[STATUS_ID_LSB +: ID_W] = int_id;
      end
    endcase
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: a vector table for the main request /
// ack / eret flow, then hand-written sequences for W1C withdrawal, sources
// arriving during service, set-versus-clear collisions and async reset.
module tb_int_controller;

`ifdef INT_SYNC_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_req;
  logic [3:0]  int_id;
  logic        int_ack;
  logic        eret;

  int n_checks = 0;
  int n_errors = 0;

  int_controller dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .int_req   (int_req),
    .int_id    (int_id),
    .int_ack   (int_ack),
    .eret      (eret)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic        pad;
    logic        exp_req;
    logic [3:0]  exp_id;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic [7:0] s, logic w, logic [1:0] a, logic [31:0] d,
                              logic k, logic e, logic p, logic rq, logic [3:0] id,
                              logic [31:0] rd);
    vec_t v;
    v.src = s; v.we = w; v.addr = a; v.wdata = d; v.ack = k; v.eret = e;
    v.pad = p; v.exp_req = rq; v.exp_id = id; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs settle and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(logic [1:0] a, logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic read_check(string name, logic [1:0] a, logic [31:0] exp);
    reg_addr = a;
    #1;
    check(name, reg_rdata, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  // Wait a bounded number of cycles for int_req, then check the id
  task automatic wait_req(string name, logic [3:0] exp_id);
    int cyc = 0;
    while (!int_req && cyc < 10) begin
      step();
      cyc++;
    end
    check({name, "_req"}, {31'b0, int_req}, 32'd1);
    check({name, "_id"}, {28'b0, int_id}, {28'b0, exp_id});
  endtask

  initial begin
    rst = 1'b1; src_in = '0; reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = '0;
    int_ack = 1'b0; eret = 1'b0;

    // Reset state
    step(); step();
    check("rst_req", {31'b0, int_req}, 32'd0);
    check("rst_id", {28'b0, int_id}, 32'd0);
    read_check("rst_mask", 2'd0, 32'h0);
    read_check("rst_pending", 2'd1, 32'h0);
    read_check("rst_ctrl", 2'd2, 32'h0);
    read_check("rst_status", 2'd3, 32'h0);
    rst = 1'b0;
    step(); step(); step(); step();

    //           src    we  addr  wdata  ack eret pad req id  rdata
    vecs[0]  = mk(8'h00, 1, 2'd0, 32'hFF, 0, 0, 0, 0, 0, 32'h0FF);
    vecs[1]  = mk(8'h00, 1, 2'd2, 32'h01, 0, 0, 0, 0, 0, 32'h001);
    vecs[2]  = mk(8'h08, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 32'h008);
    vecs[3]  = mk(8'h08, 0, 2'd3, 32'h00, 0, 0, 0, 1, 3, 32'h301);
    vecs[4]  = mk(8'h08, 0, 2'd1, 32'h00, 1, 0, 0, 0, 3, 32'h000);
    vecs[5]  = mk(8'h08, 0, 2'd3, 32'h00, 0, 0, 0, 0, 3, 32'h302);
    vecs[6]  = mk(8'h08, 0, 2'd3, 32'h00, 0, 1, 0, 0, 3, 32'h300);
    vecs[7]  = mk(8'h2A, 0, 2'd1, 32'h00, 0, 0, 1, 0, 3, 32'h022);
    vecs[8]  = mk(8'h2A, 0, 2'd3, 32'h00, 0, 0, 0, 1, 1, 32'h101);
    vecs[9]  = mk(8'h2A, 0, 2'd1, 32'h00, 1, 0, 0, 0, 1, 32'h020);
    vecs[10] = mk(8'h2A, 0, 2'd3, 32'h00, 0, 1, 0, 0, 1, 32'h100);
    vecs[11] = mk(8'h2A, 0, 2'd3, 32'h00, 0, 0, 0, 1, 5, 32'h501);
    vecs[12] = mk(8'h2A, 0, 2'd3, 32'h00, 1, 0, 0, 0, 5, 32'h502);
    vecs[13] = mk(8'h00, 0, 2'd3, 32'h00, 0, 1, 0, 0, 5, 32'h500);
    vecs[14] = mk(8'h00, 1, 2'd0, 32'h00, 0, 0, 0, 0, 5, 32'h000);
    vecs[15] = mk(8'h04, 0, 2'd1, 32'h00, 0, 0, 1, 0, 5, 32'h004);
    vecs[16] = mk(8'h04, 0, 2'd3, 32'h00, 0, 0, 0, 0, 5, 32'h500);
    vecs[17] = mk(8'h04, 1, 2'd0, 32'h04, 0, 0, 0, 0, 5, 32'h004);
    vecs[18] = mk(8'h04, 0, 2'd3, 32'h00, 0, 0, 0, 1, 2, 32'h201);
    vecs[19] = mk(8'h04, 0, 2'd3, 32'h00, 1, 0, 0, 0, 2, 32'h202);
    vecs[20] = mk(8'h00, 0, 2'd3, 32'h00, 0, 1, 0, 0, 2, 32'h200);

    for (int i = 0; i < 21; i++) begin
      src_in = vecs[i].src;
      if (vecs[i].pad) begin
        for (int k = 0; k < PAD; k++) step();
      end
      reg_we = vecs[i].we; reg_addr = vecs[i].addr; reg_wdata = vecs[i].wdata;
      int_ack = vecs[i].ack; eret = vecs[i].eret;
      step();
      check($sformatf("vec%0d_req", i), {31'b0, int_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_id", i), {28'b0, int_id}, {28'b0, vecs[i].exp_id});
      check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rd);
      reg_we = 1'b0; int_ack = 1'b0; eret = 1'b0; reg_wdata = '0;
    end

    // W1C withdraws a request that was never acked
    reg_write(2'd0, 32'hFF);
    src_in = 8'h10;
    wait_req("w1c_arm", 4'd4);
    reg_write(2'd1, 32'h10);
    step();
    check("w1c_req", {31'b0, int_req}, 32'd0);
    read_check("w1c_status", 2'd3, 32'h400);
    src_in = 8'h00;
    step();

    // A source rising during service waits for eret
    src_in = 8'h02;
    wait_req("svc_first", 4'd1);
    pulse_ack();
    read_check("svc_status", 2'd3, 32'h102);
    src_in = 8'h03;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("svc_hold%0d", k), {31'b0, int_req}, 32'd0);
    end
    read_check("svc_pending", 2'd1, 32'h01);
    pulse_eret();
    wait_req("svc_after_eret", 4'd0);
    pulse_ack();
    pulse_eret();
    src_in = 8'h00;
    step();

`ifndef INT_SYNC_EN
    // New edge and W1C of the same bit in one cycle: the set wins
    reg_write(2'd0, 32'h00);
    src_in = 8'h80;
    reg_write(2'd1, 32'h80);
    read_check("setwins_pending", 2'd1, 32'h80);
    reg_write(2'd1, 32'h80);
    read_check("w1c_clear", 2'd1, 32'h00);
    src_in = 8'h00;
    step();
`endif

    // Async reset while in REQ, with a source held high through deassertion
    reg_write(2'd0, 32'hFF);
    src_in = 8'h40;
    wait_req("rst_arm", 4'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, int_req}, 32'd0);
    check("arst_id", {28'b0, int_id}, 32'd0);
    read_check("arst_mask", 2'd0, 32'h0);
    read_check("arst_pending", 2'd1, 32'h0);
    read_check("arst_ctrl", 2'd2, 32'h0);
    read_check("arst_status", 2'd3, 32'h0);
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reg_write(2'd0, 32'hFF);
    reg_write(2'd2, 32'h01);
    step(); step(); step();
    check("held_req", {31'b0, int_req}, 32'd0);
    read_check("held_pending", 2'd1, 32'h0);
    src_in = 8'h00;
    step();
    src_in = 8'h40;
    wait_req("rearm", 4'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
